// File: rtl/swan64_serial_round_ctrl.sv
// SWAN64 serial round sequencer: one 8-bit column per cycle, four cycles per Feistel round.
// Define SWAN_CTRL_ABORT_EN to add an abort input that drops the block in flight.
module swan64_serial_round_ctrl #(
    parameter int unsigned BLOCK_SIZE = 64,
    parameter int unsigned ROUNDS     = 32,
    parameter int unsigned RW         = 6,
    parameter int unsigned PA         = 1,
    parameter int unsigned PB         = 2,
    parameter int unsigned PC         = 7
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BLOCK_SIZE-1:0] in_data,
    output logic [RW-1:0]         rk_idx,
    input  logic [31:0]           rk,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BLOCK_SIZE-1:0] out_data,
`ifdef SWAN_CTRL_ABORT_EN
    input  logic                  abort,
`endif
    output logic                  busy
);

    localparam int unsigned Half = BLOCK_SIZE / 2;
    localparam logic [RW-1:0] RndLast = RW'(ROUNDS - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e          state_q, state_d;
    logic [Half-1:0] l_q, l_d, r_q, r_d;
    logic [1:0]      col_q, col_d;
    logic [RW-1:0]   rnd_q, rnd_d;

    logic [4:0]      col_sh;
    logic [2:0]      rot_amt;
    logic [7:0]      mix, rot;
    logic [Half-1:0] r_upd;
    logic            last_col;
    logic            kill;

    function automatic logic [7:0] rotr8(input logic [7:0] a, input logic [2:0] p);
        logic [15:0] dbl;
        dbl = {a, a} >> p;
        return dbl[7:0];
    endfunction

    // Column 0 is the most significant byte of each half.
    assign col_sh   = {~col_q, 3'b000};
    assign last_col = (col_q == 2'd3);

    always_comb begin
        unique case (col_q)
            2'd0:    rot_amt = 3'(PC);
            2'd1:    rot_amt = 3'(PB);
            2'd2:    rot_amt = 3'(PA);
            default: rot_amt = 3'd0;
        endcase
    end

    assign mix   = l_q[col_sh +: 8] ^ rk[col_sh +: 8];
    assign rot   = rotr8(mix, rot_amt);
    assign r_upd = r_q ^ ({{(Half - 8){1'b0}}, rot} << col_sh);

`ifdef SWAN_CTRL_ABORT_EN
    assign kill = abort && (state_q != StIdle);
`else
    assign kill = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (in_valid) state_d = StRun;
            StRun:   if (last_col && rnd_q == RndLast) state_d = StDone;
            StDone:  if (out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (kill) state_d = StIdle;
    end

    always_comb begin
        in_ready  = (state_q == StIdle);
        busy      = (state_q == StRun);
        out_valid = (state_q == StDone);
        out_data  = (state_q == StDone) ? {l_q, r_q} : '0;
        rk_idx    = rnd_q;
    end

    always_comb begin
        l_d   = l_q;
        r_d   = r_q;
        col_d = col_q;
        rnd_d = rnd_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    l_d   = in_data[Half +: Half];
                    r_d   = in_data[0 +: Half];
                    col_d = 2'd0;
                    rnd_d = '0;
                end
            end
            StRun: begin
                col_d = col_q + 2'd1;
                if (last_col) begin
                    // Last column and the Feistel swap share one edge.
                    l_d   = r_upd;
                    r_d   = l_q;
                    rnd_d = (rnd_q == RndLast) ? '0 : rnd_q + 1'b1;
                end else begin
                    r_d = r_upd;
                end
            end
            default: ;
        endcase
        if (kill) begin
            l_d   = '0;
            r_d   = '0;
            col_d = 2'd0;
            rnd_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            l_q   <= '0;
            r_q   <= '0;
            col_q <= 2'd0;
            rnd_q <= '0;
        end else begin
            l_q   <= l_d;
            r_q   <= r_d;
            col_q <= col_d;
            rnd_q <= rnd_d;
        end
    end

endmodule

// File: tb/tb_swan64_serial_round_ctrl.sv
// Scoreboard bench for swan64_serial_round_ctrl: a ROUNDS=1 and a ROUNDS=32 instance share clock,
// reset and a key table; a queue-driven monitor checks every output on each falling edge.
module tb_swan64_serial_round_ctrl;

    localparam int RW = 6;
    localparam int PA = 1;
    localparam int PB = 2;
    localparam int PC = 7;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [63:0] data;
        int          acc;
    } txn_t;

    txn_t qa[$];
    txn_t qb[$];

    logic [31:0] keys [64];

    logic          a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy;
    logic [63:0]   a_in_data, a_out_data;
    logic [RW-1:0] a_rk_idx;
    logic [31:0]   a_rk;
    logic          b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
    logic [63:0]   b_in_data, b_out_data;
    logic [RW-1:0] b_rk_idx;
    logic [31:0]   b_rk;
`ifdef SWAN_CTRL_ABORT_EN
    logic          a_abort, b_abort;
`endif

    assign a_rk = keys[a_rk_idx];
    assign b_rk = keys[b_rk_idx];

    swan64_serial_round_ctrl #(.ROUNDS(1)) dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_data   (a_in_data),
        .rk_idx    (a_rk_idx),
        .rk        (a_rk),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_data  (a_out_data),
`ifdef SWAN_CTRL_ABORT_EN
        .abort     (a_abort),
`endif
        .busy      (a_busy)
    );

    swan64_serial_round_ctrl #(.ROUNDS(32)) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_data   (b_in_data),
        .rk_idx    (b_rk_idx),
        .rk        (b_rk),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_data  (b_out_data),
`ifdef SWAN_CTRL_ABORT_EN
        .abort     (b_abort),
`endif
        .busy      (b_busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int rotr8(input int v, input int p);
        return ((v >> p) | (v << (8 - p))) & 'hff;
    endfunction

    // Feistel rounds straight from the column rules; key for round n is keys[n].
    function automatic logic [63:0] swan_ref(input logic [63:0] blk, input int rounds);
        logic [31:0] l, r, t;
        int sh, p, x;
        l = blk[63:32];
        r = blk[31:0];
        for (int n = 0; n < rounds; n++) begin
            for (int j = 0; j < 4; j++) begin
                sh = 24 - 8 * j;
                p  = (j == 0) ? PC : (j == 1) ? PB : (j == 2) ? PA : 0;
                x  = int'(((l >> sh) ^ (keys[n] >> sh)) & 32'hff);
                r  = r ^ (32'(rotr8(x, p)) << sh);
            end
            t = l;
            l = r;
            r = t;
        end
        return {l, r};
    endfunction

    task automatic mon(input string tag, input int rounds, input bit pend, input txn_t t,
                       input logic rdy, input logic ov, input logic bsy,
                       input logic [63:0] od, input logic [RW-1:0] idx);
        int el;
        bit done;
        el   = pend ? cyc - t.acc : 0;
        done = pend && (el >= 4 * rounds);
        chk({tag, ".in_ready"}, 64'(rdy), 64'(!pend));
        chk({tag, ".busy"}, 64'(bsy), 64'(pend && !done));
        chk({tag, ".out_valid"}, 64'(ov), 64'(done));
        chk({tag, ".out_data"}, od, done ? t.data : 64'd0);
        chk({tag, ".rk_idx"}, 64'(idx), (pend && !done) ? 64'(el / 4) : 64'd0);
    endtask

    always @(negedge clk) begin
        txn_t t;
        t.data = '0;
        t.acc  = 0;
        if (qa.size() != 0) t = qa[0];
        mon("a", 1, qa.size() != 0, t, a_in_ready, a_out_valid, a_busy, a_out_data, a_rk_idx);
        if (a_out_valid && a_out_ready && qa.size() != 0) void'(qa.pop_front());
    end

    always @(negedge clk) begin
        txn_t t;
        t.data = '0;
        t.acc  = 0;
        if (qb.size() != 0) t = qb[0];
        mon("b", 32, qb.size() != 0, t, b_in_ready, b_out_valid, b_busy, b_out_data, b_rk_idx);
        if (b_out_valid && b_out_ready && qb.size() != 0) void'(qb.pop_front());
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input bit on_b, input logic [63:0] blk, input logic [63:0] exp);
        txn_t t;
        if (on_b) begin
            b_in_data  = blk;
            b_in_valid = 1'b1;
        end else begin
            a_in_data  = blk;
            a_in_valid = 1'b1;
        end
        tick();
        a_in_valid = 1'b0;
        b_in_valid = 1'b0;
        t.data = exp;
        t.acc  = cyc;
        if (on_b) qb.push_back(t);
        else qa.push_back(t);
    endtask

    task automatic finish_block(input bit on_b, input int rounds, input int hold, input bit noise);
        int n;
        n = 0;
        while (!(on_b ? b_out_valid : a_out_valid) && n < 4 * rounds + 8) begin
            if (on_b && noise) begin
                b_in_valid = 1'($urandom_range(0, 1));
                b_in_data  = {$urandom, $urandom};
            end
            tick();
            n++;
        end
        b_in_valid = 1'b0;
        if (n >= 4 * rounds + 8) begin
            total++;
            bad++;
            $display("FAIL %s.timeout: no out_valid after %0d cycles, required within %0d",
                     on_b ? "b" : "a", n, 4 * rounds);
            qa.delete();
            qb.delete();
            rst_n = 1'b0;
            tick();
            rst_n = 1'b1;
            return;
        end
        repeat (hold) tick();
        if (on_b) b_out_ready = 1'b1;
        else a_out_ready = 1'b1;
        tick();
        a_out_ready = 1'b0;
        b_out_ready = 1'b0;
    endtask

    task automatic rand_b(input int hold);
        logic [63:0] blk;
        for (int i = 0; i < 32; i++) keys[i] = $urandom;
        blk = {$urandom, $urandom};
        send(1'b1, blk, swan_ref(blk, 32));
        finish_block(1'b1, 32, hold, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] blk;
        rst_n       = 1'b0;
        a_in_valid  = 1'b0;
        b_in_valid  = 1'b0;
        a_in_data   = '0;
        b_in_data   = '0;
        a_out_ready = 1'b0;
        b_out_ready = 1'b0;
`ifdef SWAN_CTRL_ABORT_EN
        a_abort     = 1'b0;
        b_abort     = 1'b0;
`endif
        for (int i = 0; i < 64; i++) keys[i] = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Single-round column vectors.
        send(1'b0, 64'h0100000000000000, 64'h0200000001000000);
        finish_block(1'b0, 1, 0, 1'b0);
        send(1'b0, 64'h0080000000000000, 64'h0020000000800000);
        finish_block(1'b0, 1, 0, 1'b0);
        send(1'b0, 64'h0000800000000000, 64'h0000400000008000);
        finish_block(1'b0, 1, 0, 1'b0);
        send(1'b0, 64'h0000008000000000, 64'h0000008000000080);
        finish_block(1'b0, 1, 0, 1'b0);
        keys[0] = 32'h01000000;
        send(1'b0, 64'h0, 64'h0200000000000000);
        finish_block(1'b0, 1, 2, 1'b0);

        for (int i = 0; i < 4; i++) begin
            keys[0] = $urandom;
            blk     = {$urandom, $urandom};
            send(1'b0, blk, swan_ref(blk, 1));
            finish_block(1'b0, 1, int'($urandom_range(0, 2)), 1'b0);
        end

        // 32-round random blocks; first one held 5 cycles in DONE.
        rand_b(5);
        for (int i = 0; i < 4; i++) rand_b(int'($urandom_range(0, 3)));

        // Reset in the middle of RUN discards the block.
        for (int i = 0; i < 32; i++) keys[i] = $urandom;
        blk = {$urandom, $urandom};
        send(1'b1, blk, swan_ref(blk, 32));
        repeat (10) tick();
        rst_n = 1'b0;
        qb.delete();
        #1;
        chk("rst.in_ready", 64'(b_in_ready), 64'd1);
        chk("rst.out_valid", 64'(b_out_valid), 64'd0);
        chk("rst.out_data", b_out_data, 64'd0);
        chk("rst.busy", 64'(b_busy), 64'd0);
        chk("rst.rk_idx", 64'(b_rk_idx), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        rand_b(1);

`ifdef SWAN_CTRL_ABORT_EN
        for (int i = 0; i < 32; i++) keys[i] = $urandom;
        blk = {$urandom, $urandom};
        send(1'b1, blk, swan_ref(blk, 32));
        repeat (6) tick();
        b_abort = 1'b1;
        tick();
        b_abort = 1'b0;
        qb.delete();
        chk("abort.in_ready", 64'(b_in_ready), 64'd1);
        chk("abort.out_valid", 64'(b_out_valid), 64'd0);
        repeat (6) tick();
        // Abort in IDLE does not block acceptance.
        for (int i = 0; i < 32; i++) keys[i] = $urandom;
        blk     = {$urandom, $urandom};
        b_abort = 1'b1;
        send(1'b1, blk, swan_ref(blk, 32));
        b_abort = 1'b0;
        finish_block(1'b1, 32, 0, 1'b0);
`endif

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/swan64_serial_round_ctrl.md
# swan64_serial_round_ctrl

Sequencer for the SWAN64 serial datapath. It accepts one 64-bit block, runs ROUNDS Feistel rounds, and returns the result. Each round applies the vartheta column rotation to one 8-bit column per cycle, so a round takes 4 cycles. Round keys come from the external key schedule through a combinational index/key port pair. The block sits between the block-level valid/ready interface and the key schedule.

## Interface
- BLOCK_SIZE, 64, block width; half = 32, column = 8 (fixed values).
- ROUNDS, 32, rounds per block; legal range 1..2**RW-1.
- RW, 6, width of the round counter and of rk_idx.
- PA, 1, right-rotation of column 2.
- PB, 2, right-rotation of column 1.
- PC, 7, right-rotation of column 0 (column 3 is not rotated).
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  input block valid.
- in_ready  out  1  high only in IDLE.
- in_data  in  64  bits [0:31] = L, [32:63] = R; bit 0 is the MSB.
- rk_idx  out  RW  current round number (0..ROUNDS-1).
- rk  in  32  round key for rk_idx; valid combinationally in the same cycle.
- out_valid  out  1  result valid.
- out_ready  in  1  result consumed.
- out_data  out  64  {L,R} after the last round.
- busy  out  1  high in RUN.

## Operation
- States: IDLE, RUN, DONE.
- Registers: L[0:31], R[0:31], col (2 bits), rnd (RW bits).
- Column j of a half is bits [8j:8j+7]. rotr(a,p) = {a[8-p:7], a[0:7-p]}. Rotation per column: p0 = PC, p1 = PB, p2 = PA, p3 = 0.
- IDLE:
  - in_ready = 1.
  - On in_valid: L, R ← in_data; col, rnd ← 0; go to RUN.
- RUN, each cycle, for column j = col:
  - R_j ← R_j ^ rotr(L_j ^ rk_j, p_j).
  - col increments.
- RUN, when col = 3:
  - Column 3 update and swap happen in the same edge: L ← updated R, R ← old L.
  - col ← 0; rnd increments.
  - If rnd = ROUNDS-1, go to DONE instead.
- DONE:
  - out_valid = 1; out_data = {L,R}.
  - On out_ready: go to IDLE.
- rk_idx = rnd at all times (0 in IDLE and DONE).
- All XORs are 8-bit. There is no carry or width growth.

## Timing
- Reset values: state = IDLE, L = R = 0, col = 0, rnd = 0.
- Output reset values: in_ready = 1, out_valid = 0, out_data = 0, busy = 0, rk_idx = 0.
- Handshake rules:
  - Input is accepted on an edge where in_valid & in_ready.
  - Output is consumed on an edge where out_valid & out_ready.
  - No combinational path from in_valid to in_ready, or from out_ready to out_valid.
- Latency: input accepted at edge t → busy from t; out_valid rises at edge t + 4·ROUNDS. Throughput is one block per 4·ROUNDS + 2 cycles minimum.
- DONE holds out_data stable indefinitely while out_ready = 0.
- in_valid during RUN or DONE is ignored (in_ready = 0). No input is accepted in the same cycle an output is consumed; IDLE is always visited.
- rk must be stable for the whole 4-cycle round. The rk_idx change coincides with the swap edge.
- Asserting rst_n low mid-RUN or mid-DONE clears immediately to the reset values; the partial block is discarded.
- ROUNDS = 1: exactly one pass of 4 cycles, then DONE.

## Configuration
- SWAN_CTRL_ABORT_EN defined:
  - Adds input abort (1 bit).
  - abort high in RUN or DONE → next edge goes to IDLE with L = R = 0, col = rnd = 0, out_valid = 0; no output is produced.
  - abort in IDLE is ignored. If in_valid and abort are both high in IDLE, the input is still accepted.
- SWAN_CTRL_ABORT_EN undefined: no abort port; RUN always completes.

## Test plan
- ROUNDS=1, rk=0, in_data=0x0100000000000000 → out_data=0x0200000001000000, out_valid exactly 4 cycles after acceptance.
- ROUNDS=1, rk=0, in_data=0x0080000000000000 → out_data=0x0020000000800000 (column 1, rotr 2).
- ROUNDS=1, rk=0, in_data=0x0000800000000000 → 0x0000400000008000 (column 2, rotr 1); in_data=0x0000008000000000 → 0x0000008000000080 (column 3, no rotation).
- ROUNDS=1, rk=0x01000000, in_data=0 → out_data=0x0200000000000000.
- ROUNDS=32, random data with a reference model: rk_idx steps 0..31 once every 4 cycles; out_valid held 5 cycles with out_ready=0, data stable; in_valid pulses during RUN are ignored.
- Reset and abort:
  - rst_n low at cycle 10 of RUN → all outputs at reset values on the next sample; a new block then completes normally.
  - With SWAN_CTRL_ABORT_EN, abort at cycle 7 → in_ready=1 next cycle, no out_valid.
